param_stack: RTL and testbench

Parametrised LIFO stack that succeeds the fixed 8-bit stack. Data width and depth are configurable. Adds full/empty/count status, separate sticky overflow and underflow flags with a clear input, and a single-cycle replace-top operation on simultaneous push and pop. It is used as a generic return-address and operand stack wherever the design needs last-in-first-out buffering.

---
 rtl/stack_pkg.sv | 19 +
 rtl/stack_ram.sv | 25 ++
 rtl/param_stack.sv | 120 ++++++++++++
 tb/tb_param_stack.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared definitions for the parametrised LIFO stack: op encoding and sizing helper.
package stack_pkg;

  localparam logic [1:0] OP_NONE    = 2'd0;
  localparam logic [1:0] OP_PUSH    = 2'd1;
  localparam logic [1:0] OP_POP     = 2'd2;
  localparam logic [1:0] OP_REPLACE = 2'd3;

  // Smallest r with 2**r >= v; usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/stack_ram.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port, no reset.
module stack_ram
  import stack_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/param_stack.sv
// Parametrised LIFO stack with count/full/empty status, sticky overflow/underflow
// flags and a replace-top operation on simultaneous push and pop.
module param_stack
  import stack_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned CNT_W = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  input  logic             err_clr,
  output logic [WIDTH-1:0] data_out,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow,
  output logic             error
);

  localparam int unsigned AW = (DEPTH > 1) ? clog2(DEPTH) : 1;

  logic [CNT_W-1:0] r_sp;
  logic             r_overflow;
  logic             r_underflow;

  logic [1:0]       w_op;
  logic             w_empty;
  logic             w_full;
  logic             w_we;
  logic [CNT_W-1:0] w_waddr;
  logic [CNT_W-1:0] w_top;
  logic [WIDTH-1:0] w_rdata;
  logic             w_ovf_evt;
  logic             w_unf_evt;

  assign w_empty = (r_sp == '0);
  assign w_full  = (r_sp == CNT_W'(DEPTH));
  assign w_top   = w_empty ? '0 : (r_sp - CNT_W'(1));

  // Decode the request pair into a single operation.
  always_comb begin
    w_op = OP_NONE;
    if (push && !pop)      w_op = OP_PUSH;
    else if (pop && !push) w_op = OP_POP;
    else if (push && pop)  w_op = OP_REPLACE;
  end

  always_comb begin
    w_we      = 1'b0;
    w_waddr   = r_sp;
    w_ovf_evt = 1'b0;
    w_unf_evt = 1'b0;
    case (w_op)
      OP_PUSH: begin
        w_we      = !w_full;
        w_waddr   = r_sp;
        w_ovf_evt = w_full;
      end
      OP_POP: begin
        w_unf_evt = w_empty;
      end
      OP_REPLACE: begin
        w_we      = !w_empty;
        w_waddr   = w_top;
        w_unf_evt = w_empty;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sp <= '0;
    end else if (w_op == OP_PUSH && !w_full) begin
      r_sp <= r_sp + CNT_W'(1);
    end else if (w_op == OP_POP && !w_empty) begin
      r_sp <= r_sp - CNT_W'(1);
    end
  end

  // Sticky flags: a new error event on the clearing edge takes priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovf_evt)    r_overflow <= 1'b1;
      else if (err_clr) r_overflow <= 1'b0;
      if (w_unf_evt)    r_underflow <= 1'b1;
      else if (err_clr) r_underflow <= 1'b0;
    end
  end

  stack_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (AW'(w_waddr)),
    .i_wdata (data_in),
    .i_raddr (AW'(w_top)),
    .o_rdata (w_rdata)
  );

  assign data_out  = w_empty ? '0 : w_rdata;
  assign count     = r_sp;
  assign empty     = w_empty;
  assign full      = w_full;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;
  assign error     = r_overflow | r_underflow;

endmodule

// File: tb/tb_param_stack.sv
// Self-checking bench for param_stack: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_param_stack;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CNT_W = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             push, pop, err_clr;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic [CNT_W-1:0] count;
  logic             empty, full, overflow, underflow, error;

  int n_cmp = 0;
  int n_bad = 0;

  param_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .data_in   (data_in),
    .err_clr   (err_clr),
    .data_out  (data_out),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow),
    .error     (error)
  );

  always #5 clk = ~clk;

  // Reference model: the stack as a queue, top at the back.
  logic [WIDTH-1:0] m_q[$];
  bit               m_ovf, m_unf;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      bit ov, un;
      ov = push && !pop && (m_q.size() == DEPTH);
      un = pop && (m_q.size() == 0);
      if (push && !pop && m_q.size() < DEPTH) m_q.push_back(data_in);
      else if (pop && !push && m_q.size() > 0) void'(m_q.pop_back());
      else if (push && pop && m_q.size() > 0) m_q[m_q.size()-1] = data_in;
      m_ovf = ov || (m_ovf && !err_clr);
      m_unf = un || (m_unf && !err_clr);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  bit model_on = 1'b0;

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_on) begin
      logic [WIDTH-1:0] exp_top;
      exp_top = (m_q.size() == 0) ? '0 : m_q[m_q.size()-1];
      chk("m_count", 32'(count), 32'(m_q.size()));
      chk("m_data_out", 32'(data_out), 32'(exp_top));
      chk("m_empty", 32'(empty), 32'(m_q.size() == 0));
      chk("m_full", 32'(full), 32'(m_q.size() == DEPTH));
      chk("m_overflow", 32'(overflow), 32'(m_ovf));
      chk("m_underflow", 32'(underflow), 32'(m_unf));
      chk("m_error", 32'(error), 32'(m_ovf || m_unf));
    end
  end

  task automatic step(input logic p, input logic o, input logic [WIDTH-1:0] d, input logic c);
    push = p; pop = o; data_in = d; err_clr = c;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; err_clr = 1'b0;
  endtask

  initial begin
    reset = 1'b1; push = 1'b0; pop = 1'b0; err_clr = 1'b0; data_in = '0;
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    model_on = 1'b1;
    @(posedge clk); #1;

    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_data_out", 32'(data_out), 0);
    chk("rst_error", 32'(error), 0);

    for (int i = 0; i < 16; i++) begin
      step(1, 0, 8'(i), 0);
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_top", 32'(data_out), 32'(i));
    end
    chk("fill_full", 32'(full), 1);
    chk("fill_ovf", 32'(overflow), 0);

    step(1, 0, 8'hAA, 0);
    chk("ovf_count", 32'(count), 16);
    chk("ovf_top", 32'(data_out), 32'h0F);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_error", 32'(error), 1);
    step(0, 0, 8'h00, 1);
    chk("ovf_clr", 32'(overflow), 0);

    for (int i = 0; i < 16; i++) begin
      chk("drain_top", 32'(data_out), 32'(15 - i));
      step(0, 1, 8'h00, 0);
    end
    chk("drain_empty", 32'(empty), 1);
    chk("drain_data0", 32'(data_out), 0);
    step(0, 1, 8'h00, 0);
    chk("unf_flag", 32'(underflow), 1);
    chk("unf_count", 32'(count), 0);
    step(0, 0, 8'h00, 1);

    step(1, 0, 8'h11, 0);
    step(1, 0, 8'h22, 0);
    step(1, 1, 8'h33, 0);
    chk("rep_count", 32'(count), 2);
    chk("rep_top", 32'(data_out), 32'h33);
    step(0, 1, 8'h00, 0);
    chk("rep_pop_top", 32'(data_out), 32'h11);
    for (int i = 0; i < 15; i++) step(1, 0, 8'(8'h60 + i), 0);
    chk("rep_full", 32'(full), 1);
    step(1, 1, 8'h55, 0);
    chk("repfull_top", 32'(data_out), 32'h55);
    chk("repfull_count", 32'(count), 16);
    chk("repfull_ovf", 32'(overflow), 0);
    for (int i = 0; i < 16; i++) step(0, 1, 8'h00, 0);
    step(1, 1, 8'h77, 0);
    chk("repempty_count", 32'(count), 0);
    chk("repempty_unf", 32'(underflow), 1);
    step(0, 0, 8'h00, 1);
    chk("clr_unf", 32'(underflow), 0);

    step(0, 1, 8'h00, 1);
    chk("evt_wins_clr", 32'(underflow), 1);
    step(0, 0, 8'h00, 1);
    chk("clr_alone", 32'(underflow), 0);

    // Reset mid-stream with five entries and a pending flag.
    step(0, 1, 8'h00, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 8'(8'hC0 + i), 0);
    chk("pre_rst_count", 32'(count), 5);
    push = 1'b1; data_in = 8'hEE;
    reset = 1'b1;
    #2;
    chk("mid_rst_count", 32'(count), 0);
    @(posedge clk); #3;
    push = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_count", 32'(count), 0);
    chk("post_rst_empty", 32'(empty), 1);
    chk("post_rst_flags", 32'({overflow, underflow}), 0);

    // Randomized traffic with drifting push/pop bias so both boundaries get exercised.
    for (int blk = 0; blk < 8; blk++) begin
      int unsigned bias;
      bias = (blk % 2 == 0) ? 75 : 25;
      for (int i = 0; i < 250; i++) begin
        logic p, o, c;
        p = ($urandom_range(99) < bias);
        o = ($urandom_range(99) < (100 - bias));
        c = ($urandom_range(99) < 8);
        step(p, o, 8'($urandom), c);
      end
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
